// File: rtl/arbiter_grant_lock.sv
// arbiter_grant_lock: registers the arbiter's one-hot grant and holds it for a whole transfer
module arbiter_grant_lock #(
  parameter int SIZE = 4,
  parameter int COUNT_WIDTH = 8,
  parameter int MAX_BEATS = 16,
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [SIZE-1:0]        requests,
  input  logic [SIZE-1:0]        arbiter_grant,
  input  logic                   transfer_ready,
  input  logic                   transfer_last,
  output logic [SIZE-1:0]        grant,
  output logic [IW-1:0]          grant_index,
  output logic                   grant_valid,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic                   timeout
);
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam logic [COUNT_WIDTH:0] max_v = (COUNT_WIDTH+1)'(MAX_BEATS);
  state_t state, state_n;
  logic [SIZE-1:0] capture, grant_n;
  logic [IW-1:0] enc, index_n;
  logic [COUNT_WIDTH-1:0] count_n, count_inc, count_sat;
  logic valid_n, timeout_n, r, beat, hit_max, release_n;
  always_comb begin
    enc = '0;
    for (int i = 0; i < SIZE; i++) if (capture[i]) enc = IW'(i);
  end
  assign capture = arbiter_grant & requests;
  assign r = requests[grant_index];
  assign beat = r & transfer_ready;
  assign count_inc = beat_count + 1'b1;
  assign count_sat = &beat_count ? beat_count : count_inc;
  assign hit_max = (MAX_BEATS != 0) && ({1'b0, beat_count} + 1'b1 == max_v);
  // abort, last beat and timeout all release; last beat outranks timeout
  assign release_n = (state == LOCKED) && (!r || (beat && (transfer_last || hit_max)));
  always_comb begin
    state_n = state;
    grant_n = grant;
    index_n = grant_index;
    valid_n = grant_valid;
    count_n = beat_count;
    timeout_n = 1'b0;
    if (state == IDLE && |capture) begin
      state_n = LOCKED;
      grant_n = capture;
      index_n = enc;
      valid_n = 1'b1;
      count_n = '0;
    end
    if (state == LOCKED && beat) begin
      count_n = transfer_last ? count_inc : hit_max ? max_v[COUNT_WIDTH-1:0] : count_sat;
      timeout_n = !transfer_last && hit_max;
    end
    if (release_n) begin
      state_n = IDLE;
      grant_n = '0;
      valid_n = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
      beat_count <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_index <= index_n;
      grant_valid <= valid_n;
      beat_count <= count_n;
      timeout <= timeout_n;
    end
  end
  always_ff @(posedge clock) begin
    if (resetn) begin
      assert ($onehot0(arbiter_grant));
      assert (grant_valid == |grant);
      assert ($onehot0(grant));
    end
  end
endmodule

// File: tb/tb_arbiter_grant_lock.sv
// tb_arbiter_grant_lock: directed checks on three parameterisations sharing one stimulus
module tb_arbiter_grant_lock;
  logic clock = 1'b0;
  logic resetn, transfer_ready, transfer_last;
  logic [3:0] requests, arbiter_grant;
  logic [3:0] grant_a, grant_t, grant_s;
  logic [1:0] index_a, index_t, index_s;
  logic valid_a, valid_t, valid_s, to_a, to_t, to_s;
  logic [7:0] count_a, count_t;
  logic [2:0] count_s;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clock = ~clock;
  arbiter_grant_lock u_a (
    .clock(clock), .resetn(resetn), .requests(requests), .arbiter_grant(arbiter_grant),
    .transfer_ready(transfer_ready), .transfer_last(transfer_last), .grant(grant_a),
    .grant_index(index_a), .grant_valid(valid_a), .beat_count(count_a), .timeout(to_a)
  );
  arbiter_grant_lock #(.MAX_BEATS(4)) u_t (
    .clock(clock), .resetn(resetn), .requests(requests), .arbiter_grant(arbiter_grant),
    .transfer_ready(transfer_ready), .transfer_last(transfer_last), .grant(grant_t),
    .grant_index(index_t), .grant_valid(valid_t), .beat_count(count_t), .timeout(to_t)
  );
  arbiter_grant_lock #(.COUNT_WIDTH(3), .MAX_BEATS(0)) u_s (
    .clock(clock), .resetn(resetn), .requests(requests), .arbiter_grant(arbiter_grant),
    .transfer_ready(transfer_ready), .transfer_last(transfer_last), .grant(grant_s),
    .grant_index(index_s), .grant_valid(valid_s), .beat_count(count_s), .timeout(to_s)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic [3:0] req, input logic [3:0] ag, input logic tr, input logic tl);
    requests = req;
    arbiter_grant = ag;
    transfer_ready = tr;
    transfer_last = tl;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    resetn = 1'b1;
  endtask
  initial begin
    resetn = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("rst_grant", grant_a, 4'b0000);
    check("rst_index", index_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_count", count_a, 0);
    check("rst_timeout", to_a, 0);
    drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    tick();
    check("cap_grant", grant_a, 4'b0100);
    check("cap_index", index_a, 2);
    check("cap_valid", valid_a, 1);
    check("cap_count", count_a, 0);
    drive(4'b0101, 4'b0001, 1'b1, 1'b0);
    tick();
    check("pre_b1_grant", grant_a, 4'b0100);
    check("pre_b1_count", count_a, 1);
    tick();
    check("pre_b2_grant", grant_a, 4'b0100);
    check("pre_b2_count", count_a, 2);
    transfer_last = 1'b1;
    tick();
    check("pre_last_count", count_a, 3);
    check("pre_last_valid", valid_a, 0);
    check("pre_last_grant", grant_a, 4'b0000);
    check("pre_last_timeout", to_a, 0);
    check("pre_last_index_hold", index_a, 2);
    drive(4'b0101, 4'b0001, 1'b0, 1'b0);
    tick();
    check("rearb_grant", grant_a, 4'b0001);
    check("rearb_index", index_a, 0);
    check("rearb_count", count_a, 0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    check("drop_valid", valid_a, 0);
    drive(4'b0010, 4'b0010, 1'b0, 1'b0);
    tick();
    check("abort_cap_index", index_a, 1);
    transfer_ready = 1'b1;
    repeat (2) tick();
    check("abort_pre_count", count_a, 2);
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    check("abort_count", count_a, 2);
    check("abort_valid", valid_a, 0);
    check("abort_timeout", to_a, 0);
    do_reset();
    drive(4'b1000, 4'b1000, 1'b0, 1'b0);
    tick();
    check("to_cap_grant", grant_t, 4'b1000);
    check("to_cap_index", index_t, 3);
    transfer_ready = 1'b1;
    repeat (3) tick();
    check("to_b3_count", count_t, 3);
    check("to_b3_valid", valid_t, 1);
    check("to_b3_timeout", to_t, 0);
    tick();
    check("to_b4_count", count_t, 4);
    check("to_b4_valid", valid_t, 0);
    check("to_b4_timeout", to_t, 1);
    tick();
    check("to_pulse_end", to_t, 0);
    check("to_relock_valid", valid_t, 1);
    check("to_relock_count", count_t, 0);
    repeat (3) tick();
    check("tl_b3_count", count_t, 3);
    transfer_last = 1'b1;
    tick();
    check("tl_b4_count", count_t, 4);
    check("tl_b4_valid", valid_t, 0);
    check("tl_b4_timeout", to_t, 0);
    do_reset();
    drive(4'b0001, 4'b0001, 1'b0, 1'b0);
    tick();
    check("sat_cap_grant", grant_s, 4'b0001);
    check("sat_cap_count", count_s, 0);
    transfer_ready = 1'b1;
    tick();
    check("sat_r1", count_s, 1);
    transfer_ready = 1'b0;
    tick();
    check("sat_r0a", count_s, 1);
    tick();
    check("sat_r0b", count_s, 1);
    transfer_ready = 1'b1;
    tick();
    check("sat_r1b", count_s, 2);
    repeat (5) tick();
    check("sat_reach", count_s, 7);
    repeat (5) tick();
    check("sat_hold", count_s, 7);
    check("sat_valid", valid_s, 1);
    check("sat_grant", grant_s, 4'b0001);
    check("sat_timeout", to_s, 0);
    do_reset();
    drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    tick();
    transfer_ready = 1'b1;
    repeat (5) tick();
    check("mid_count", count_a, 5);
    check("mid_valid", valid_a, 1);
    transfer_ready = 1'b0;
    resetn = 1'b0;
    tick();
    check("mid_rst_grant", grant_a, 4'b0000);
    check("mid_rst_index", index_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_count", count_a, 0);
    check("mid_rst_timeout", to_a, 0);
    resetn = 1'b1;
    tick();
    check("post_rst_grant", grant_a, 4'b0100);
    check("post_rst_valid", valid_a, 1);
    check("post_rst_index", index_a, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
